// File: rtl/data_island_packet_scheduler_if.sv
// Slot/frame strobes and audio inputs from the timing side, packet grant and
// status outputs toward the assembler.
interface data_island_packet_scheduler_if;
    logic       packet_slot;
    logic       frame_start;
    logic       clk_audio_counter_wrap;
    logic [2:0] sample_level;
    logic       packet_valid;
    logic [7:0] packet_type;
    logic [2:0] sample_pop_count;
    logic       acr_overrun;
    logic       slot_collision;

    modport master (
        output packet_slot, frame_start, clk_audio_counter_wrap, sample_level,
        input  packet_valid, packet_type, sample_pop_count, acr_overrun, slot_collision
    );

    modport slave (
        input  packet_slot, frame_start, clk_audio_counter_wrap, sample_level,
        output packet_valid, packet_type, sample_pop_count, acr_overrun, slot_collision
    );
endinterface

// File: rtl/data_island_packet_scheduler.sv
// Chooses the HDMI data-island packet for each slot: ACR first, then audio
// samples, then pending InfoFrames (AVI, Audio IF, SPD), otherwise null.
module data_island_packet_scheduler #(
    parameter logic [2:0]  INFOFRAME_MASK = 3'b111,
    parameter bit          AUDIO_ENABLE   = 1'b1,
    parameter int unsigned PACKET_CYCLES  = 32
) (
    input logic                          clk_pixel,
    input logic                          reset_n,
    data_island_packet_scheduler_if.slave bus
);
    localparam int unsigned   CW   = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(PACKET_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] busy_cnt;
    logic          wrap_q;
    logic          acr_pending;
    logic [2:0]    if_pending;

    logic          acr_evt;
    logic          accept;
    logic          grant_acr;
    logic          grant_audio;
    logic [2:0]    if_grant;
    logic [7:0]    next_type;
    logic [2:0]    next_pop;

    // BUSY with busy_cnt at 0 is the last cycle of the packet, so a slot
    // exactly PACKET_CYCLES after the previous grant is already accepted.
    always_comb begin
        acr_evt     = bus.clk_audio_counter_wrap ^ wrap_q;
        accept      = bus.packet_slot && (state == IDLE || busy_cnt == '0);
        grant_acr   = acr_pending | acr_evt;
        grant_audio = AUDIO_ENABLE && !grant_acr && (bus.sample_level != '0);
        if_grant    = '0;
        next_type   = 8'h00;
        next_pop    = '0;
        if (grant_acr) begin
            next_type = 8'h01;
        end else if (grant_audio) begin
            next_type = 8'h02;
            next_pop  = (bus.sample_level > 3'd4) ? 3'd4 : bus.sample_level;
        end else if (if_pending[0]) begin
            next_type = 8'h82;
            if_grant  = 3'b001;
        end else if (if_pending[1]) begin
            next_type = 8'h84;
            if_grant  = 3'b010;
        end else if (if_pending[2]) begin
            next_type = 8'h83;
            if_grant  = 3'b100;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            busy_cnt             <= '0;
            wrap_q               <= 1'b0;
            acr_pending          <= 1'b0;
            if_pending           <= '0;
            bus.packet_valid     <= 1'b0;
            bus.packet_type      <= 8'h00;
            bus.sample_pop_count <= '0;
            bus.acr_overrun      <= 1'b0;
            bus.slot_collision   <= 1'b0;
        end else begin
            wrap_q               <= bus.clk_audio_counter_wrap;
            bus.packet_valid     <= accept;
            bus.packet_type      <= accept ? next_type : 8'h00;
            bus.sample_pop_count <= accept ? next_pop : 3'd0;

            // A fresh event arriving with a granted pending ACR keeps one owed.
            if (accept && grant_acr)
                acr_pending <= acr_pending & acr_evt;
            else
                acr_pending <= acr_pending | acr_evt;

            if (acr_evt && acr_pending && !(accept && grant_acr))
                bus.acr_overrun <= 1'b1;
            if (bus.packet_slot && !accept)
                bus.slot_collision <= 1'b1;

            if_pending <= (if_pending & ~(accept ? if_grant : 3'b000))
                        | (bus.frame_start ? INFOFRAME_MASK : 3'b000);

            if (accept) begin
                state    <= BUSY;
                busy_cnt <= LOAD;
            end else if (state == BUSY) begin
                if (busy_cnt == '0)
                    state <= IDLE;
                else
                    busy_cnt <= busy_cnt - 1'b1;
            end
        end
    end
endmodule

// File: doc/data_island_packet_scheduler.md
# data_island_packet_scheduler

Selects which HDMI data-island packet is transmitted in each packet slot: audio clock regeneration (ACR), audio sample, InfoFrames (AVI, Audio, SPD) or null. It sits in the `clk_pixel` domain between the video timing generator, which provides slot and frame strobes, and the packet assembler/serializer. It consumes the toggle-style ACR wrap flag and the audio sample FIFO level. It guarantees that every ACR event is sent exactly once and that InfoFrames go out once per frame.

## Interface
Parameters:
- `INFOFRAME_MASK`, 3'b111 — enables for {SPD, Audio IF, AVI}; bit 0 = AVI.
- `AUDIO_ENABLE`, 1 — 0 disables audio sample packets (FIFO level ignored, `sample_pop_count` stays 0).
- `PACKET_CYCLES`, 32 — clk_pixel cycles one packet occupies on the link.

Ports:
- `clk_pixel` in 1 — pixel clock; sole clock.
- `reset_n` in 1 — reset, asynchronous and active-low.
- `packet_slot` in 1 — one-cycle strobe: a packet may start on the next cycle.
- `frame_start` in 1 — one-cycle strobe at the start of each frame.
- `clk_audio_counter_wrap` in 1 — toggle from the ACR generator, already in `clk_pixel`; each transition means one ACR packet is owed.
- `sample_level` in 3 — samples available in the audio FIFO, 0..7.
- `packet_valid` out 1 — one-cycle grant strobe.
- `packet_type` out 8 — HB0 of the granted packet: 0x00 null, 0x01 ACR, 0x02 audio sample, 0x82 AVI, 0x84 Audio IF, 0x83 SPD.
- `sample_pop_count` out 3 — samples the assembler pops; valid with `packet_valid`, otherwise 0.
- `acr_overrun` out 1 — sticky: an ACR event arrived while one was already pending.
- `slot_collision` out 1 — sticky: `packet_slot` arrived while the link was busy.

## Operation
- Wrap edge: `wrap_q` registers `clk_audio_counter_wrap`. `acr_evt = clk_audio_counter_wrap ^ wrap_q`.
- `acr_evt` sets `acr_pending`.
  - `acr_evt` with `acr_pending` already set and not being granted this cycle sets `acr_overrun`. Only one ACR remains owed.
- `frame_start` ORs `INFOFRAME_MASK` into `if_pending[2:0]`. Pending bits from the previous frame stay set; this is not an error.
- FSM states:
  - IDLE: on `packet_slot`, decide, go to BUSY, load `busy_cnt = PACKET_CYCLES-1`.
  - BUSY: `busy_cnt` decrements each cycle. At 0, return to IDLE.
  - `packet_slot` in BUSY is ignored (no grant) and sets `slot_collision`.
- Decision priority (evaluated in the `packet_slot` cycle):
  1. ACR, if `acr_pending | acr_evt`. An event in the slot cycle itself is eligible.
  2. Audio sample, if `AUDIO_ENABLE` and `sample_level != 0`. `sample_pop_count = min(sample_level, 4)`.
  3. InfoFrame, lowest set bit of `if_pending`: AVI, then Audio IF, then SPD.
  4. Null.
- The granted source's pending bit clears on the decision edge.
  - If `acr_evt` coincides with an ACR grant of an already-pending ACR, `acr_pending` stays set; that is a second event and not an overrun.
- A `frame_start` in the same cycle as `packet_slot` sets `if_pending` after the decision. Those InfoFrames are not eligible in that slot.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - All outputs 0; `packet_type = 0x00`.
  - `acr_pending = 0`, `if_pending = 0`, FSM in IDLE, `busy_cnt = 0`.
  - `wrap_q = 0` (the ACR toggle also resets to 0).
- Latency: `packet_valid`, `packet_type` and `sample_pop_count` are registered, asserted exactly 1 cycle after the accepted `packet_slot`, for exactly 1 cycle.
- `packet_type` returns to 0x00 when `packet_valid` is low.
- Minimum accepted slot spacing is `PACKET_CYCLES`. A slot exactly `PACKET_CYCLES` cycles after the previous accepted slot is accepted.
- `reset_n` asserted mid-packet drops `packet_valid` immediately (async) and clears all pending state. After deassertion, the first slot yields null unless new events arrive.

## Test plan
- Reset, one toggle of wrap, slot 5 cycles later -> `packet_valid` 1 cycle after slot, `packet_type` 0x01; next slot (≥32 cycles later) with no events -> 0x00.
- `sample_level` = 6, ACR pending, two slots 32 apart -> first 0x01 with pop 0, second 0x02 with pop 4.
- `frame_start`, `sample_level` 0, four slots 32 apart -> 0x82, 0x84, 0x83, 0x00. With `INFOFRAME_MASK` = 3'b010 -> 0x84, 0x00.
- Wrap toggles twice with no slot between -> `acr_overrun` = 1. Next slot 0x01, following slot 0x00 (no duplicate).
- Slots at t and t+10 -> second ignored, `slot_collision` = 1. Slot at t+32 is granted.
- Wrap toggle coincident with slot -> 0x01 granted, no overrun. `frame_start` coincident with slot (no other pending) -> 0x00, then 0x82 on the next slot. `reset_n` low mid-BUSY -> all outputs 0 asynchronously.
